// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder
//   Receive-side monitor for a 4-bit two-phase full-step coil pattern.
//   Synchronises the coil lines, decodes legal phase transitions into
//   steps with direction, keeps a wrapping signed position count, flags
//   illegal patterns / 180-degree jumps, and reports active motion.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   phase_in   coil pattern, asynchronous to clk
//   pos_clr    single-cycle request to zero position
//   err_clr    single-cycle request to clear sticky err
//   position   two's-complement step count (wraps)
//   dir        direction of last valid step, 1 = forward
//   step_pulse one-cycle pulse per decoded step
//   err        sticky illegal-pattern / phase-jump flag
//   moving     high while steps arrive within TIMEOUT cycles
//
// Decode outcome | meaning
//   idle         | s2 = 0000 or s2 = lv, nothing happens
//   dec_err      | s2 not legal and not 0000, err set
//   dec_acq      | first legal pattern since reset, lv captured, no step
//   dec_fwd      | s2 = rotl(lv), forward step
//   dec_rev      | s2 = rotr(lv), reverse step
//   dec_jump     | s2 = ~lv, err set, lv follows, no step

module stepper_phase_decoder #(
   parameter int POS_W   = 16,
   parameter int TIMEOUT = 2048,
   parameter int TO_W    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       phase_in,
   input  logic             pos_clr,
   input  logic             err_clr,
   output logic [POS_W-1:0] position,
   output logic             dir,
   output logic             step_pulse,
   output logic             err,
   output logic             moving
);

   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

   logic [3:0]      s1;
   logic [3:0]      s2;
   logic [3:0]      lv;
   logic            lv_valid;
   logic [TO_W-1:0] idle_cnt;
   logic [TO_W-1:0] idle_next;

   logic dec_err;
   logic dec_acq;
   logic dec_fwd;
   logic dec_rev;
   logic dec_jump;
   logic step;

   function automatic logic is_legal(input logic [3:0] p);
      return (p == 4'b0011) || (p == 4'b0110) || (p == 4'b1100) || (p == 4'b1001);
   endfunction

   function automatic logic [3:0] rotl(input logic [3:0] p);
      return {p[2:0], p[3]};
   endfunction

   function automatic logic [3:0] rotr(input logic [3:0] p);
      return {p[0], p[3:1]};
   endfunction

   always_comb begin
      dec_err  = 1'b0;
      dec_acq  = 1'b0;
      dec_fwd  = 1'b0;
      dec_rev  = 1'b0;
      dec_jump = 1'b0;
      if (s2 != 4'b0000) begin
         if (!is_legal(s2)) begin
            dec_err = 1'b1;
         end else if (!lv_valid) begin
            dec_acq = 1'b1;
         end else if (s2 != lv) begin
            if (s2 == rotl(lv)) begin
               dec_fwd = 1'b1;
            end else if (s2 == rotr(lv)) begin
               dec_rev = 1'b1;
            end else begin
               // only remaining legal pattern is the complement of lv
               dec_jump = 1'b1;
            end
         end
      end
   end

   assign step = dec_fwd | dec_rev;

   always_comb begin
      idle_next = idle_cnt;
      if (step) begin
         idle_next = '0;
      end else if (idle_cnt < TO_MAX) begin
         idle_next = idle_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 4'b0000;
         s2         <= 4'b0000;
         lv         <= 4'b0000;
         lv_valid   <= 1'b0;
         position   <= '0;
         dir        <= 1'b0;
         step_pulse <= 1'b0;
         err        <= 1'b0;
         idle_cnt   <= TO_MAX;
         moving     <= 1'b0;
      end else begin
         s1         <= phase_in;
         s2         <= s1;
         step_pulse <= step;

         if (dec_acq | step | dec_jump) begin
            lv <= s2;
         end
         if (dec_acq) begin
            lv_valid <= 1'b1;
         end

         if (dec_fwd) begin
            dir <= 1'b1;
         end else if (dec_rev) begin
            dir <= 1'b0;
         end

         // clear beats a coincident step; step_pulse/dir still update
         if (pos_clr) begin
            position <= '0;
         end else if (dec_fwd) begin
            position <= position + POS_W'(1);
         end else if (dec_rev) begin
            position <= position - POS_W'(1);
         end

         // a coincident error wins over the clear request
         if (dec_err | dec_jump) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end

         idle_cnt <= idle_next;
         moving   <= (idle_next < TO_MAX);
      end
   end

endmodule
